seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Run-time programmable serial pattern detector controller: loads a 1..MAX_LEN-bit pattern via a
//  valid/ready config port, arms/disarms on start/stop, and scans a qualified serial bit stream.
//  Registered one-cycle match pulse (Mealy decision, registered output); optional match counter.
//  Sits between the host register interface and the serial line front end.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=2)
//  CNT_W    8  match counter width
//  LEN_W = $clog2(MAX_LEN+1) (derived localparam)
// PORTS
//  clk           in   1        clock
//  reset         in   1        asynchronous, active-high reset
//  cfg_valid     in   1        config request
//  cfg_ready     out  1        config accept; 1 in IDLE and READY, 0 in RUN
//  cfg_pattern   in   MAX_LEN  pattern; bit len-1 = first-received bit
//  cfg_len       in   LEN_W    pattern length
//  cfg_overlap   in   1        1 = overlapping matches allowed
//  cfg_err       out  1        1-cycle pulse: config rejected
//  start         in   1        arm scan
//  stop          in   1        disarm scan
//  in_valid      in   1        in_bit qualifier
//  in_bit        in   1        serial data
//  busy          out  1        1 while in RUN
//  match         out  1        1-cycle pulse, cycle after the completing bit is accepted
//  match_count   out  CNT_W    matches since last start
// BEHAVIOUR
//  Reset: state IDLE; pattern/len/overlap/history/fill = 0; busy=0, match=0, cfg_err=0, count=0.
//  Reset mid-RUN aborts immediately; configuration is lost (back to IDLE).
//  FSM: IDLE -(cfg accepted)-> READY -(start)-> RUN -(stop)-> READY. No other transitions.
//  Config: handshake = cfg_valid&cfg_ready. cfg_len==0 or >MAX_LEN -> rejected: cfg_err pulses
//   next cycle, state and stored config unchanged. Valid -> store, clear history/fill, go READY.
//  start honoured only in READY (ignored elsewhere); on entry to RUN: history, fill, count cleared.
//  cfg_valid and start in the same READY cycle: config accepted, start ignored.
//  RUN: each in_valid cycle shifts in_bit into history (newest at bit 0); fill saturates at len.
//   Hit = (fill+1 >= len) && history_next[len-1:0] == pattern[len-1:0]; match registered -> 1-cycle latency.
//   Overlap=0: on a hit, history and fill cleared. Overlap=1: history retained.
//   in_valid=0: no shift, no match. Bits outside RUN ignored.
//  stop in RUN: READY next cycle; bit accepted in the stop cycle is still evaluated (match may pulse
//   the cycle after, with busy already 0). start in RUN ignored.
//  match_count: +1 per match, saturates at 2^CNT_W-1, holds value in READY, cleared only on start/reset.
// CONFIGURATION
//  SEQ_DETECT_CTRL_COUNT_EN defined: match_count counter built as above.
//  Not defined: no counter logic; match_count port present, tied to 0.
// STRUCTURE
//  seq_detect_pkg: state enum typedef (IDLE, READY, RUN), LEN_W computation function.
//  Sub-module seq_match_core: history shift register, fill counter, masked compare, overlap clear;
//   the controller owns FSM, config registers, handshake, counter, output registers.
// TESTING
//  1. pattern=2'b11, len=2, overlap=1; stream 0,1,1,1,0,1,1 -> match after bits 3,4,7; count=3.
//  2. Same, overlap=0 -> match after bits 3,7 only; count=2.
//  3. cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulse each, cfg_ready stays 1, state IDLE.
//  4. CNT_W=2, pattern 1'b1... len=2 '11' overlap=1, six 1s -> 5 matches, count saturates at 3.
//  5. stop asserted with the completing bit -> busy 0 next cycle, match still pulses; start restarts with count=0.
//  6. reset mid-RUN with partial history -> all outputs 0, cfg_ready=1, start ignored until reconfig.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types for the serial pattern detector: controller state encoding
// and the pattern-length field width helper.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Width needed to hold a length value in 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Scan datapath: history shift register, fill counter and masked pattern
// compare. Produces a combinational hit for the bit being accepted this cycle.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               in_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);

    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] history_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W:0]     fill_inc;
    logic               enough;
    logic               pat_eq;

    always_comb begin
        history_next = {history[MAX_LEN-2:0], in_bit};
        mask         = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
        enough   = (fill_inc >= {1'b0, len});
        pat_eq   = ((history_next & mask) == (pattern & mask));
        hit      = shift_en && enough && pat_eq;
    end

    // fill saturates at len so it never wraps on long streams
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift_en) begin
            if (hit && !overlap) begin
                history <= '0;
                fill    <= '0;
            end else begin
                history <= history_next;
                fill    <= enough ? len : fill_inc[LEN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector controller: config handshake, arm/disarm
// FSM, registered match pulse. SEQ_DETECT_CTRL_COUNT_EN builds the match counter.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    state_t             state;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;

    logic cfg_hs;
    logic cfg_bad;
    logic cfg_ok;
    logic start_ok;
    logic shift_en;
    logic core_clear;
    logic hit;

    // A config handshake in READY takes precedence over a simultaneous start.
    always_comb begin
        cfg_hs     = cfg_valid && (state != RUN);
        cfg_bad    = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
        cfg_ok     = cfg_hs && !cfg_bad;
        start_ok   = start && (state == READY) && !cfg_hs;
        shift_en   = in_valid && (state == RUN);
        core_clear = cfg_ok || start_ok;
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (core_clear),
        .shift_en (shift_en),
        .in_bit   (in_bit),
        .pattern  (pattern_q),
        .len      (len_q),
        .overlap  (overlap_q),
        .hit      (hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            match     <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            match   <= hit;
            cfg_err <= cfg_hs && cfg_bad;
            if (cfg_ok) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
            end
            case (state)
                IDLE: begin
                    if (cfg_ok) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (start_ok) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                RUN: begin
                    // the bit accepted alongside stop is still scored via hit
                    if (stop) begin
                        state     <= READY;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SEQ_DETECT_CTRL_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (start_ok) begin
            count_q <= '0;
        end else if (hit && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed streams push expected pulses,
// a negedge monitor pops and compares every match / cfg_err pulse.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;

    localparam int EV_MATCH = 0;
    localparam int EV_ERR   = 1;

    logic               clk;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               start;
    logic               stop;
    logic               in_valid;
    logic               in_bit;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_count;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .busy        (busy),
        .match       (match),
        .match_count (match_count)
    );

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_cnt(input int n);
`ifdef SEQ_DETECT_CTRL_COUNT_EN
        return (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: outputs are registered, so they are stable at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (match === 1'b1)   pop(EV_MATCH);
                if (cfg_err === 1'b1) pop(EV_ERR);
            end
        end
    end

    task automatic drive(input logic cv, input logic st, input logic sp,
                         input logic iv, input logic ib);
        @(negedge clk);
        cfg_valid = cv;
        start     = st;
        stop      = sp;
        in_valid  = iv;
        in_bit    = ib;
    endtask

    task automatic tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_cfg(input logic [MAX_LEN-1:0] p, input int l,
                           input logic ov, input bit bad, input logic st);
        drive(1'b1, st, 1'b0, 1'b0, 1'b0);
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_overlap = ov;
        if (bad) exp_q.push_back('{EV_ERR, cyc + 1});
        tick();
    endtask

    // b = 2 means an idle (in_valid=0) slot
    task automatic send(input int b, input bit hit, input logic sp);
        if (b == 2) drive(1'b0, 1'b0, sp, 1'b0, 1'b0);
        else        drive(1'b0, 1'b0, sp, 1'b1, b[0]);
        if (hit) exp_q.push_back('{EV_MATCH, cyc + 1});
    endtask

    task automatic run_stream(input int bits[8], input int hits[8]);
        for (int i = 0; i < 8; i++) send(bits[i], hits[i] != 0, 1'b0);
    endtask

    task automatic arm();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic disarm();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    int t1_bits[8] = '{0, 1, 2, 1, 1, 0, 1, 1};
    int t1_ov[8]   = '{0, 0, 0, 1, 1, 0, 0, 1};
    int t1_no[8]   = '{0, 0, 0, 1, 0, 0, 0, 1};
    int t4_bits[8] = '{1, 1, 1, 1, 1, 1, 2, 2};
    int t4_hits[8] = '{0, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_match", match, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_count", match_count, 0);

        // bad lengths rejected in IDLE; start ignored while unconfigured
        set_cfg(8'h03, 0, 1'b1, 1'b1, 1'b0);
        check("len0_ready", cfg_ready, 1);
        set_cfg(8'h03, MAX_LEN + 1, 1'b1, 1'b1, 1'b0);
        check("len9_ready", cfg_ready, 1);
        arm();
        check("idle_start_busy", busy, 0);
        send(1, 0, 1'b0);
        send(1, 0, 1'b0);
        tick();
        tick();
        check("t3_drain", exp_q.size(), 0);

        // '11' overlapping
        set_cfg(8'h03, 2, 1'b1, 1'b0, 1'b0);
        check("t1_ready_busy", busy, 0);
        arm();
        check("t1_busy", busy, 1);
        check("t1_cfg_ready", cfg_ready, 0);
        run_stream(t1_bits, t1_ov);
        disarm();
        check("t1_stop_busy", busy, 0);
        check("t1_stop_ready", cfg_ready, 1);
        tick();
        check("t1_count", match_count, exp_cnt(3));
        check("t1_drain", exp_q.size(), 0);

        // '11' non-overlapping; rejected reconfig in READY must not disturb it
        set_cfg(8'h03, 2, 1'b0, 1'b0, 1'b0);
        set_cfg(8'h03, MAX_LEN + 1, 1'b1, 1'b1, 1'b0);
        arm();
        check("t2_busy", busy, 1);
        check("t2_count_clr", match_count, 0);
        run_stream(t1_bits, t1_no);
        disarm();
        tick();
        check("t2_count", match_count, exp_cnt(2));
        check("t2_drain", exp_q.size(), 0);

        // counter saturation: six 1s, five matches
        set_cfg(8'h03, 2, 1'b1, 1'b0, 1'b0);
        arm();
        run_stream(t4_bits, t4_hits);
        disarm();
        tick();
        check("t4_count_sat", match_count, exp_cnt(5));
        check("t4_drain", exp_q.size(), 0);

        // config + start together: config wins, stays READY
        set_cfg(8'b101, 3, 1'b0, 1'b0, 1'b1);
        check("cfg_start_busy", busy, 0);
        arm();
        check("t5_busy", busy, 1);
        send(1, 0, 1'b0);
        send(0, 0, 1'b0);
        send(1, 1, 1'b1);
        tick();
        check("t5_stop_busy", busy, 0);
        tick();
        check("t5_count_hold", match_count, exp_cnt(1));
        send(1, 0, 1'b0);
        send(0, 0, 1'b0);
        send(1, 0, 1'b0);
        arm();
        check("t5_restart_busy", busy, 1);
        check("t5_restart_count", match_count, 0);
        send(1, 0, 1'b0);
        send(0, 0, 1'b0);
        send(1, 1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("t5_run_start_ign", match_count, exp_cnt(1));
        check("t5_drain", exp_q.size(), 0);

        // async reset mid-RUN with partial history
        send(1, 0, 1'b0);
        send(0, 0, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_match", match, 0);
        check("t6_cfg_err", cfg_err, 0);
        check("t6_count", match_count, 0);
        check("t6_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        arm();
        check("t6_start_ign", busy, 0);
        send(1, 0, 1'b0);
        set_cfg(8'b101, 3, 1'b0, 1'b0, 1'b0);
        arm();
        check("t6_rearm_busy", busy, 1);
        send(1, 0, 1'b0);
        send(0, 0, 1'b0);
        send(1, 1, 1'b0);
        disarm();
        tick();
        check("t6_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
